// File: rtl/gamepad_pkg.sv
// rtl/gamepad_pkg.sv - shared types and constants for the NES-style gamepad reader
package gamepad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_WAIT_LO,
    ST_CLK_HI,
    ST_DONE
  } state_e;

  localparam int NUM_BUTTONS = 8;

  // Serial bit positions as shifted out by the pad after a latch
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with a parameterised reset value
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gamepad_reader.sv
// rtl/gamepad_reader.sv - polls an NES-style pad and presents registered button levels
module gamepad_reader
  import gamepad_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 300,
  parameter int LATCH_CYCLES    = 600,
  parameter int POLL_CYCLES     = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic raw_btn_up,
  output logic raw_btn_down,
  output logic raw_btn_left,
  output logic raw_btn_right,
  output logic raw_btn_A,
  output logic raw_btn_B,
  output logic raw_btn_start,
  output logic raw_btn_select,
  output logic frame_done,
  output logic pad_connected
);

  localparam int CNT_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int PW      = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          poll_q, poll_d;
  logic [2:0]             idx_q, idx_d;
  logic [NUM_BUTTONS-1:0] shift_q, shift_d;
  logic [NUM_BUTTONS-1:0] btn_q, btn_d;
  logic                   conn_q, conn_d;
  logic                   pend_q, pend_d;
  logic                   first_q;
  logic                   latch_q, pclk_q, done_q;
  logic                   poll_wrap, req, pad_sync;

  sync2 #(.RESET_VAL(1'b1)) u_sync_data (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (pad_data),
    .q_o     (pad_sync)
  );

  always_comb begin
    poll_wrap = (poll_q == PW'(POLL_CYCLES - 1));
    poll_d    = poll_wrap ? '0 : poll_q + 1'b1;
    req       = first_q | poll_wrap;
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    pend_d    = pend_q | req;
    btn_d     = btn_q;
    conn_d    = conn_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pend_q || req) begin
          state_d = ST_LATCH;
          pend_d  = 1'b0;
        end
      end
      ST_LATCH: begin
        idx_d = '0;
        if (cnt_q == CW'(LATCH_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (cnt_q == CW'(HALF_BIT_CYCLES - 1)) begin
          cnt_d          = '0;
          shift_d[idx_q] = ~pad_sync;
          state_d        = (idx_q == 3'(NUM_BUTTONS - 1)) ? ST_DONE : ST_CLK_HI;
        end
      end
      ST_CLK_HI: begin
        if (cnt_q == CW'(HALF_BIT_CYCLES - 1)) begin
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          state_d = ST_WAIT_LO;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Outputs load on the edge into DONE so they appear together with frame_done
    if (state_d == ST_DONE) begin
      conn_d = (shift_d != '1);
      btn_d  = conn_d ? shift_d : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      poll_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      btn_q   <= '0;
      conn_q  <= 1'b0;
      pend_q  <= 1'b0;
      first_q <= 1'b1;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      poll_q  <= poll_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      btn_q   <= btn_d;
      conn_q  <= conn_d;
      pend_q  <= pend_d;
      first_q <= 1'b0;
      latch_q <= (state_d == ST_LATCH);
      pclk_q  <= (state_d == ST_CLK_HI);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign pad_latch      = latch_q;
  assign pad_clk        = pclk_q;
  assign frame_done     = done_q;
  assign pad_connected  = conn_q;
  assign raw_btn_A      = btn_q[BTN_A];
  assign raw_btn_B      = btn_q[BTN_B];
  assign raw_btn_select = btn_q[BTN_SELECT];
  assign raw_btn_start  = btn_q[BTN_START];
  assign raw_btn_up     = btn_q[BTN_UP];
  assign raw_btn_down   = btn_q[BTN_DOWN];
  assign raw_btn_left   = btn_q[BTN_LEFT];
  assign raw_btn_right  = btn_q[BTN_RIGHT];

endmodule

// File: tb/tb_gamepad_reader.sv
// tb/tb_gamepad_reader.sv - directed self-checking bench for gamepad_reader
module tb_gamepad_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic pad_data, pad_latch, pad_clk, frame_done, pad_connected;
  logic b_up, b_down, b_left, b_right, b_a, b_b, b_start, b_select;
  logic pad_latch2, pad_clk2, frame_done2, pad_connected2;
  logic c_up, c_down, c_left, c_right, c_a, c_b, c_start, c_select;
  logic [7:0] btns;

  gamepad_reader #(.HALF_BIT_CYCLES(4), .LATCH_CYCLES(8), .POLL_CYCLES(200)) dut (
    .clk(clk), .reset(reset), .pad_data(pad_data), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .raw_btn_up(b_up), .raw_btn_down(b_down), .raw_btn_left(b_left), .raw_btn_right(b_right),
    .raw_btn_A(b_a), .raw_btn_B(b_b), .raw_btn_start(b_start), .raw_btn_select(b_select),
    .frame_done(frame_done), .pad_connected(pad_connected)
  );

  gamepad_reader #(.HALF_BIT_CYCLES(4), .LATCH_CYCLES(8), .POLL_CYCLES(70)) dut2 (
    .clk(clk), .reset(reset), .pad_data(1'b1), .pad_latch(pad_latch2), .pad_clk(pad_clk2),
    .raw_btn_up(c_up), .raw_btn_down(c_down), .raw_btn_left(c_left), .raw_btn_right(c_right),
    .raw_btn_A(c_a), .raw_btn_B(c_b), .raw_btn_start(c_start), .raw_btn_select(c_select),
    .frame_done(frame_done2), .pad_connected(pad_connected2)
  );

  assign btns = {b_right, b_left, b_down, b_up, b_start, b_select, b_b, b_a};

  // Pad model: latch reloads, each pad_clk rising edge advances to the next button
  logic [7:0] pressed = 8'h00;
  logic       tie_low = 1'b0;
  logic [3:0] pidx = 4'd0;
  logic       pclk_prev = 1'b0;
  always @(posedge clk) begin
    if (pad_latch) pidx <= 4'd0;
    else if (pad_clk && !pclk_prev) pidx <= pidx + 4'd1;
    pclk_prev <= pad_clk;
  end
  assign pad_data = tie_low ? 1'b0 : ((pidx < 4'd8) ? ~pressed[pidx[2:0]] : 1'b1);

  int checks = 0;
  int errors = 0;
  int cyc = 0, lat_start = 0, lat_len = 0, hi_run = 0, bad_width = 0;
  int fd_cyc = 0, prev_fd_cyc = 0, fd_count = 0, glitch = 0;
  int fd2_cyc = 0, fd2_count = 0, gap2 = 0, period2 = 0;
  logic prev_latch = 1'b0, prev_pclk = 1'b0, prev_latch2 = 1'b0;
  logic [7:0] prev_btns = 8'h00;

  always @(negedge clk) begin
    if (pad_latch && !prev_latch) begin
      lat_start = cyc;
      lat_len   = 0;
    end
    if (pad_latch) lat_len++;
    if (pad_clk) hi_run++;
    else if (prev_pclk) begin
      if (hi_run != 4) bad_width++;
      hi_run = 0;
    end
    if (frame_done) begin
      prev_fd_cyc = fd_cyc;
      fd_cyc      = cyc;
      fd_count++;
    end
    if (btns !== prev_btns && !frame_done) glitch++;
    if (pad_latch2 && !prev_latch2) gap2 = cyc - fd2_cyc;
    if (frame_done2) begin
      if (fd2_count > 0) period2 = cyc - fd2_cyc;
      fd2_cyc = cyc;
      fd2_count++;
    end
    prev_latch  = pad_latch;
    prev_pclk   = pad_clk;
    prev_latch2 = pad_latch2;
    prev_btns   = btns;
    cyc++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic wait_fd(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 2000);
    check({tag, "_frame_done_seen"}, int'(frame_done), 1);
    #1;
  endtask

  task automatic wait_falls(input int cnt);
    int n = 0;
    int falls = 0;
    logic last = 1'b0;
    while (falls < cnt && n < 1000) begin
      @(negedge clk);
      n++;
      if (last && !pad_clk) falls++;
      last = pad_clk;
    end
    check("pclk_falls_seen", falls, cnt);
  endtask

  initial begin
    int n;
    int fdc;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_latch", int'(pad_latch), 0);
    check("rst_pclk", int'(pad_clk), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_connected", int'(pad_connected), 0);
    check("rst_btns", int'(btns), 0);
    reset = 1'b0;

    // Idle pad: timing of the first frame
    wait_fd("idle");
    check("latch_len", lat_len, 8);
    check("frame_len", fd_cyc - lat_start, 68);
    check("pclk_width_bad", bad_width, 0);
    check("idle_btns", int'(btns), 0);
    check("idle_connected", int'(pad_connected), 1);
    @(negedge clk);
    check("frame_done_one_cycle", int'(frame_done), 0);

    // A + Left pressed
    pressed = 8'h41;
    wait_fd("a_left");
    check("a_left_btns", int'(btns), 8'h41);
    wait_fd("a_left_hold");
    check("poll_interval", fd_cyc - prev_fd_cyc, 200);
    check("a_left_btns_hold", int'(btns), 8'h41);
    check("no_glitch_hold", glitch, 0);

    // Pad absent (data tied low), then a valid pad returns
    tie_low = 1'b1;
    wait_fd("absent");
    check("absent_connected", int'(pad_connected), 0);
    check("absent_btns", int'(btns), 0);
    tie_low = 1'b0;
    pressed = 8'h82;
    wait_fd("restored");
    check("restored_connected", int'(pad_connected), 1);
    check("restored_btns", int'(btns), 8'h82);

    // Change buttons between pulses 3 and 4: bits 0..2 old, bits 3..7 new
    wait_falls(3);
    pressed = 8'h30;
    #1;
    check("mid_frame_btns_hold", int'(btns), 8'h82);
    wait_fd("midchange");
    check("midchange_btns", int'(btns), 8'h32);
    check("no_glitch_midchange", glitch, 0);
    check("pclk_width_bad_2", bad_width, 0);

    // One-cycle reset during CLK_HI of bit 5
    fdc = fd_count;
    wait_falls(5);
    n = 0;
    while (pad_clk !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_clk_hi_bit5", int'(pad_clk), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_pclk", int'(pad_clk), 0);
    check("abort_latch", int'(pad_latch), 0);
    reset = 1'b0;
    n = 0;
    while (pad_latch !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("restart_latch", int'(pad_latch), 1);
    #1;
    check("abort_no_frame_done", fd_count, fdc);
    check("abort_btns_cleared", int'(btns), 0);
    wait_fd("after_abort");
    check("after_abort_btns", int'(btns), 8'h30);
    check("after_abort_connected", int'(pad_connected), 1);

    // Short poll period: wrap lands inside the frame
    repeat (300) @(negedge clk);
    #1;
    check("short_poll_idle_gap", gap2, 2);
    check("short_poll_period", period2, 70);
    check("short_poll_frames", int'(fd2_count >= 5), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
